fixed_div_seq: RTL and testbench
================================

// Module: fixed_div_seq
// PURPOSE
//  Multi-cycle signed fixed-point divider for fixed_pkg::fixed (Q11.14, 25 b).
//  Replaces the combinational fixed_pkg::div wherever a quotient is needed.
//  Radix-2 restoring division on magnitudes, one quotient bit per clock.
//  Result is rounded to nearest and saturated. Valid/ready in, valid/ready out.
// PARAMETERS
//  TOTAL_WIDTH    fixed_pkg::TOTAL_WIDTH    operand/result width (25)
//  DECIMAL_WIDTH  fixed_pkg::DECIMAL_WIDTH  fractional bits (14)
//  ROUND          1    1 = round half away from zero, 0 = truncate toward zero
//  (localparam ITER = TOTAL_WIDTH+DECIMAL_WIDTH+1 = 40 quotient bits)
// PORTS
//  clk              in   1   clock; all logic on rising edge
//  reset            in   1   synchronous, active-high
//  in_valid         in   1   operands valid
//  in_ready         out  1   divider idle, can accept
//  in_numerator     in   25  signed fixed dividend
//  in_denominator   in   25  signed fixed divisor
//  out_valid        out  1   result valid
//  out_ready        in   1   consumer accepts result
//  out_quotient     out  25  signed fixed quotient
//  out_overflow     out  1   result saturated (range exceeded)
//  out_div_by_zero  out  1   divisor was 0
// BEHAVIOUR
//  Reset: state IDLE; out_valid, out_quotient, out_overflow, out_div_by_zero = 0.
//   Reset in any state (incl. mid-DIVIDE) aborts; the partial result is discarded.
//  One operation in flight. in_ready = (state==IDLE). out_valid = (state==DONE).
//  IDLE: on in_valid&&in_ready latch |num|, |den|, sign = num[MSB]^den[MSB],
//   num sign, dbz = (den==0). Count = ITER-1. Next: FINISH if dbz, else DIVIDE.
//   Operands only need to be valid in the accept cycle.
//  DIVIDE: remainder = {rem,next dividend bit}; if >= |den|, subtract, qbit=1.
//   The dividend is |num| << (DECIMAL_WIDTH+1), unsigned, ITER bits.
//   Count==0 -> FINISH.
//  FINISH: q2 = ITER-bit raw quotient (1 extra fraction bit).
//   mag = ROUND ? (q2+1)>>1 : q2>>1.
//   Saturate:
//    sign=0 and mag > 2^(TW-1)-1 -> +max, overflow=1
//    sign=1 and mag > 2^(TW-1)   -> -min, overflow=1
//    otherwise out = sign ? -mag : mag.
//   dbz: out = num<0 ? min : max; div_by_zero=1, overflow=0 (0/0 -> max).
//   Outputs are registered. Next: DONE.
//  DONE: outputs held stable while !out_ready. On out_ready -> IDLE.
//   Accept is possible in the next cycle; out_valid and in_ready are never both 1.
//  Latency: accept in cycle N -> out_valid in cycle N+ITER+2 (N+42).
//   For dbz the latency is N+2.
//  in_valid while busy is ignored (no accept). Output flags are valid only with out_valid.
//  Width rules: magnitude regs are TW bits unsigned (|-2^24| fits).
//   Remainder is TW+1 bits. Quotient is ITER bits. No x/z on outputs after reset.
// STRUCTURE
//  Single module, no sub-module. States IDLE/DIVIDE/FINISH/DONE as a local enum.
//  Add to fixed_pkg: localparam DIV_ITER = TOTAL_WIDTH+DECIMAL_WIDTH+1.
//  Add to fixed_pkg: constants FIXED_MAX = 2^24-1 and FIXED_MIN = -2^24.
//  Bench reference model uses fixed_pkg::rtof/ftor.
// TESTING
//  1. Basic: 49152/32768 (3.0/2.0) -> 24576 (1.5) in cycle N+42, flags 0.
//  2. Rounding, ROUND=1:
//     16384/49152 (1/3) -> 5461; -16384/49152 -> -5461.
//     1/32768 (half-LSB) -> 1; -1/32768 -> -1.
//     With ROUND=0: 1/32768 -> 0.
//  3. Div by zero: 81920/0 -> 16777215, dbz=1, cycle N+2; -81920/0 -> -16777216.
//  4. Saturation:
//     16384000/1 -> 16777215, overflow=1.
//     -16777216/16384 -> -16777216, overflow=0.
//     -16777216/-16384 -> 16777215, overflow=1.
//  5. Backpressure: out_ready low 10 cycles -> outputs stable, in_ready=0.
//     in_valid pulses while busy are not accepted.
//     Back-to-back ops run with a 1-cycle IDLE gap.
//  6. Reset at cycle N+20 -> next cycle IDLE, out_valid=0, in_ready=1.
//     A fresh op gives the correct result; 1000 random ops match the reference.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared Q11.14 fixed-point definitions: widths, range limits and
// real-number conversion helpers.
package fixed_pkg;

    localparam int TOTAL_WIDTH   = 25;
    localparam int DECIMAL_WIDTH = 14;
    localparam int DIV_ITER      = TOTAL_WIDTH + DECIMAL_WIDTH + 1;

    typedef logic signed [TOTAL_WIDTH-1:0] fixed;

    localparam fixed FIXED_MAX = {1'b0, {(TOTAL_WIDTH-1){1'b1}}};
    localparam fixed FIXED_MIN = {1'b1, {(TOTAL_WIDTH-1){1'b0}}};

    function automatic real rtof(input fixed f);
        return real'(f) / (2.0 ** DECIMAL_WIDTH);
    endfunction

    // Rounds half away from zero so ftor(rtof(x)) == x.
    function automatic fixed ftor(input real r);
        real s;
        s = r * (2.0 ** DECIMAL_WIDTH);
        s = (s >= 0.0) ? s + 0.5 : s - 0.5;
        return fixed'($rtoi(s));
    endfunction

endpackage

// File: rtl/fixed_div_seq.sv
// Sequential signed fixed-point divider: restoring division on magnitudes,
// one quotient bit per clock, then round-to-nearest and saturation.
module fixed_div_seq #(
    parameter int TOTAL_WIDTH   = fixed_pkg::TOTAL_WIDTH,
    parameter int DECIMAL_WIDTH = fixed_pkg::DECIMAL_WIDTH,
    parameter bit ROUND         = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] in_numerator,
    input  logic [TOTAL_WIDTH-1:0] in_denominator,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] out_quotient,
    output logic                   out_overflow,
    output logic                   out_div_by_zero
);

    localparam int TW   = TOTAL_WIDTH;
    localparam int ITER = TOTAL_WIDTH + DECIMAL_WIDTH + 1;
    localparam int CW   = $clog2(ITER);

    localparam logic [ITER:0]  POS_LIMIT = {{(ITER-TW+2){1'b0}}, {(TW-1){1'b1}}};
    localparam logic [ITER:0]  NEG_LIMIT = {{(ITER-TW+1){1'b0}}, 1'b1, {(TW-1){1'b0}}};
    localparam logic [TW-1:0]  MAX_VAL   = {1'b0, {(TW-1){1'b1}}};
    localparam logic [TW-1:0]  MIN_VAL   = {1'b1, {(TW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH, DONE} state_t;

    state_t            r_state, w_nextState;
    logic [TW-1:0]     r_denMag;
    logic [ITER-1:0]   r_dividend;
    logic [ITER-1:0]   r_quot;
    logic [TW:0]       r_rem;
    logic [CW-1:0]     r_count;
    logic              r_sign, r_numNeg, r_dbz;
    logic [TW-1:0]     r_quotient;
    logic              r_overflow, r_divByZero;

    logic [TW-1:0]     w_numAbs, w_denAbs, w_magLow, w_signed;
    logic [TW+1:0]     w_remShift, w_diff;
    logic              w_geq, w_denZero, w_satPos, w_satNeg;
    logic [ITER:0]     w_q2, w_mag;

    assign in_ready        = (r_state == IDLE);
    assign out_valid       = (r_state == DONE);
    assign out_quotient    = r_quotient;
    assign out_overflow    = r_overflow;
    assign out_div_by_zero = r_divByZero;

    // The most negative operand maps to 2^(TW-1), which still fits unsigned.
    assign w_numAbs  = in_numerator[TW-1]   ? (~in_numerator + 1'b1)   : in_numerator;
    assign w_denAbs  = in_denominator[TW-1] ? (~in_denominator + 1'b1) : in_denominator;
    assign w_denZero = (in_denominator == '0);

    // Sign bit of the trial subtraction doubles as the "remainder < divisor" flag.
    assign w_remShift = {r_rem, r_dividend[ITER-1]};
    assign w_diff     = w_remShift - {2'b00, r_denMag};
    assign w_geq      = ~w_diff[TW+1];

    assign w_q2     = {1'b0, r_quot};
    assign w_mag    = ROUND ? ((w_q2 + (ITER+1)'(1)) >> 1) : (w_q2 >> 1);
    assign w_satPos = ~r_sign & (w_mag > POS_LIMIT);
    assign w_satNeg =  r_sign & (w_mag > NEG_LIMIT);
    assign w_magLow = w_mag[TW-1:0];
    assign w_signed = r_sign ? (~w_magLow + 1'b1) : w_magLow;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = w_denZero ? FINISH : DIVIDE;
            DIVIDE:  if (r_count == '0) w_nextState = FINISH;
            FINISH:  w_nextState = DONE;
            DONE:    if (out_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_denMag    <= '0;
            r_dividend  <= '0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_sign      <= 1'b0;
            r_numNeg    <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_overflow  <= 1'b0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_denMag   <= w_denAbs;
                        r_dividend <= {w_numAbs, {(DECIMAL_WIDTH+1){1'b0}}};
                        r_quot     <= '0;
                        r_rem      <= '0;
                        r_count    <= CW'(ITER-1);
                        r_sign     <= in_numerator[TW-1] ^ in_denominator[TW-1];
                        r_numNeg   <= in_numerator[TW-1];
                        r_dbz      <= w_denZero;
                    end
                end
                DIVIDE: begin
                    r_rem      <= w_geq ? w_diff[TW:0] : w_remShift[TW:0];
                    r_quot     <= {r_quot[ITER-2:0], w_geq};
                    r_dividend <= r_dividend << 1;
                    r_count    <= r_count - 1'b1;
                end
                FINISH: begin
                    // Divide by zero saturates toward the numerator's sign; 0/0 gives +max.
                    if (r_dbz) begin
                        r_quotient  <= r_numNeg ? MIN_VAL : MAX_VAL;
                        r_overflow  <= 1'b0;
                        r_divByZero <= 1'b1;
                    end else begin
                        r_divByZero <= 1'b0;
                        r_overflow  <= w_satPos | w_satNeg;
                        if (w_satPos)      r_quotient <= MAX_VAL;
                        else if (w_satNeg) r_quotient <= MIN_VAL;
                        else               r_quotient <= w_signed;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Scoreboard bench for fixed_div_seq: stimulus pushes reference results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_fixed_div_seq;
    import fixed_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [24:0] in_numerator, in_denominator, out_quotient;
    logic        out_overflow, out_div_by_zero;

    logic        inValidT, inReadyT, outValidT, outReadyT;
    logic [24:0] inNumT, inDenT, outQuotT;
    logic        outOvfT, outDbzT;

    fixed_div_seq #(.ROUND(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_numerator(in_numerator), .in_denominator(in_denominator),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_overflow(out_overflow),
        .out_div_by_zero(out_div_by_zero)
    );

    fixed_div_seq #(.ROUND(1'b0)) dutTrunc (
        .clk(clk), .reset(reset),
        .in_valid(inValidT), .in_ready(inReadyT),
        .in_numerator(inNumT), .in_denominator(inDenT),
        .out_valid(outValidT), .out_ready(outReadyT),
        .out_quotient(outQuotT), .out_overflow(outOvfT),
        .out_div_by_zero(outDbzT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] quot;
        logic        ovf;
        logic        dbz;
        int unsigned acceptCycle;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    int unsigned cycleCnt = 0;
    int unsigned lastDoneCycle = 0;
    int          readyMode = 1;
    logic [24:0] heldQuot;
    logic        heldOvf, heldDbz;
    bit          prevValid = 1'b0;

    task automatic checkOutput(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passes++;
        else $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    // Reference: exact integer quotient scaled by 2^14, rounded or truncated, then clamped.
    function automatic void refDiv(input longint n, input longint d, input bit rnd,
                                   output logic [24:0] q, output bit ovf, output bit dbz);
        longint an, ad, mag;
        bit neg;
        an  = (n < 0) ? -n : n;
        ad  = (d < 0) ? -d : d;
        neg = (n < 0) != (d < 0);
        dbz = (d == 0);
        ovf = 1'b0;
        if (dbz) begin
            q = (n < 0) ? FIXED_MIN : FIXED_MAX;
        end else begin
            mag = rnd ? (an * 32768 + ad) / (2 * ad) : (an * 16384) / ad;
            if (!neg && mag > 16777215) begin
                q = FIXED_MAX; ovf = 1'b1;
            end else if (neg && mag > 16777216) begin
                q = FIXED_MIN; ovf = 1'b1;
            end else begin
                q = 25'(neg ? -mag : mag);
            end
        end
    endfunction

    function automatic longint randOperand();
        logic [24:0] v;
        int kind;
        kind = $urandom_range(0, 3);
        case (kind)
            0:       v = 25'($urandom);
            1:       v = 25'($urandom_range(0, 32768));
            2:       v = 25'($urandom_range(0, 255));
            default: v = ($urandom_range(0, 1) != 0) ? 25'h1000000 : 25'h0FFFFFF;
        endcase
        if ((kind == 1 || kind == 2) && $urandom_range(0, 1) != 0) v = -v;
        return longint'($signed(v));
    endfunction

    // Call only at a negedge; returns one negedge after the accepting edge.
    task automatic applyStimulus(input longint n, input longint d, input logic [24:0] eq,
                                 input bit eo, input bit ed);
        exp_t e;
        int waitCnt = 0;
        in_numerator   = n[24:0];
        in_denominator = d[24:0];
        in_valid       = 1'b1;
        while (!in_ready && waitCnt < 2000) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.quot = eq; e.ovf = eo; e.dbz = ed;
        e.acceptCycle = cycleCnt;
        e.lat = ed ? 2 : 42;
        sb.push_back(e);
        @(negedge clk);
        in_valid       = 1'b0;
        in_numerator   = 25'($urandom);
        in_denominator = 25'($urandom);
    endtask

    task automatic drain();
        int waitCnt = 0;
        while (sb.size() != 0 && waitCnt < 5000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("drainEmpty", sb.size(), 0);
    endtask

    task automatic runTrunc(input longint n, input longint d, input longint eq);
        int waitCnt = 0;
        inNumT   = n[24:0];
        inDenT   = d[24:0];
        inValidT = 1'b1;
        while (!inReadyT && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        @(negedge clk);
        inValidT = 1'b0;
        waitCnt  = 0;
        while (!outValidT && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        if (!outValidT) checkOutput("truncTimeout", 0, 1);
        else            checkOutput("truncQuot", longint'($signed(outQuotT)), eq);
        @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cycleCnt++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare on first presentation, then require stable outputs while stalled.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (reset) begin
            prevValid = 1'b0;
        end else begin
            if (out_valid && in_ready) checkOutput("validReadyExclusive", 1, 0);
            if (out_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedResult", 1, 0);
                end else begin
                    e = sb[0];
                    checkOutput("quotient", longint'($signed(out_quotient)), longint'($signed(e.quot)));
                    checkOutput("overflow", out_overflow, e.ovf);
                    checkOutput("divByZero", out_div_by_zero, e.dbz);
                    checkOutput("latency", longint'(cycleCnt) - longint'(e.acceptCycle), e.lat);
                end
                heldQuot = out_quotient;
                heldOvf  = out_overflow;
                heldDbz  = out_div_by_zero;
            end else if (out_valid) begin
                checkOutput("holdQuotient", out_quotient, heldQuot);
                checkOutput("holdOverflow", out_overflow, heldOvf);
                checkOutput("holdDivByZero", out_div_by_zero, heldDbz);
            end
            if (out_valid && out_ready) begin
                if (sb.size() != 0) void'(sb.pop_front());
                lastDoneCycle = cycleCnt;
            end
            prevValid = out_valid;
        end
    end

    initial begin
        logic [24:0] q;
        bit o, z;
        int waitCnt;
        int unsigned acc;

        reset = 1'b1;
        in_valid = 1'b0; in_numerator = '0; in_denominator = '0;
        inValidT = 1'b0; inNumT = '0; inDenT = '0; outReadyT = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstOutValid", out_valid, 0);
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstQuotient", out_quotient, 0);
        checkOutput("rstOverflow", out_overflow, 0);
        checkOutput("rstDivByZero", out_div_by_zero, 0);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(longint'(ftor(3.0)), longint'(ftor(2.0)), 25'(ftor(1.5)), 0, 0);
        applyStimulus(16384, 49152, 25'(5461), 0, 0);
        applyStimulus(-16384, 49152, 25'(-5461), 0, 0);
        applyStimulus(1, 32768, 25'(1), 0, 0);
        applyStimulus(-1, 32768, 25'(-1), 0, 0);
        applyStimulus(81920, 0, 25'(16777215), 0, 1);
        applyStimulus(-81920, 0, 25'(-16777216), 0, 1);
        applyStimulus(0, 0, 25'(16777215), 0, 1);
        applyStimulus(16384000, 1, 25'(16777215), 1, 0);
        applyStimulus(-16777216, 16384, 25'(-16777216), 0, 0);
        applyStimulus(-16777216, -16384, 25'(16777215), 1, 0);
        drain();

        runTrunc(1, 32768, 0);
        runTrunc(32768, 49152, 10922);
        runTrunc(-16384, 49152, -5461);

        // Stall the consumer; pulses on in_valid must not start another operation.
        readyMode = 0;
        applyStimulus(longint'(ftor(1.0)), longint'(ftor(4.0)), 25'(4096), 0, 0);
        waitCnt = 0;
        while (!out_valid && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("stallValid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            in_valid       = (i % 2 == 0);
            in_numerator   = 25'($urandom);
            in_denominator = 25'($urandom);
            @(negedge clk);
            checkOutput("stallInReady", in_ready, 0);
        end
        in_valid  = 1'b0;
        readyMode = 1;
        drain();
        repeat (3) @(negedge clk);
        checkOutput("noSpurious", out_valid, 0);

        applyStimulus(49152, 32768, 25'(24576), 0, 0);
        applyStimulus(16384, 49152, 25'(5461), 0, 0);
        checkOutput("backToBackGap", longint'(sb[$].acceptCycle) - longint'(lastDoneCycle), 1);
        drain();

        // Abort mid-division, then confirm a fresh operation is unaffected.
        applyStimulus(49152, 32768, 25'(24576), 0, 0);
        acc = sb[$].acceptCycle;
        while (cycleCnt < acc + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        checkOutput("abortOutValid", out_valid, 0);
        checkOutput("abortInReady", in_ready, 1);
        applyStimulus(-16384, 49152, 25'(-5461), 0, 0);
        drain();

        readyMode = 2;
        for (int i = 0; i < 1000; i++) begin
            longint n, d;
            n = randOperand();
            d = ($urandom_range(0, 31) == 0) ? 0 : randOperand();
            refDiv(n, d, 1'b1, q, o, z);
            applyStimulus(n, d, q, o, z);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        drain();
        readyMode = 1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
